// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared encodings and defaults for the register bus scheduler
package reg_bus_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SWAP2 = 3'd2,
        ST_SWAP3 = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant with a last-grant register
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

    logic last_q;

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/reg_bus_scheduler.sv
// rtl/reg_bus_scheduler.sv - arbitrates two requesters and sequences the register file over a shared tri-state bus
module reg_bus_scheduler
    import reg_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_op,
    input  logic [2*ADDR_W-1:0]   req_src,
    input  logic [2*ADDR_W-1:0]   req_dst,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [ADDR_W-1:0]     rf_read_addr,
    output logic                  rf_read_en,
    output logic [ADDR_W-1:0]     rf_write_addr,
    output logic                  rf_write_en,
    inout  wire  [DATA_W-1:0]     bus
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [DATA_W-1:0]   wdata_q, data_q;
    logic                owner_q;
    logic [1:0]          grant;
    logic                sel;
    logic                accept;
    logic                drv_en;
    logic [DATA_W-1:0]   drv_data;

    rr_arbiter_2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (req_valid),
        .update_i (accept),
        .grant_o  (grant)
    );

    assign sel    = grant[1];
    assign accept = |req_ready;
    assign bus    = drv_en ? drv_data : {DATA_W{1'bz}};

    always_comb begin
        state_d       = state_q;
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        rsp_data      = '0;
        rf_read_en    = 1'b0;
        rf_write_en   = 1'b0;
        drv_en        = 1'b0;
        rf_read_addr  = (state_q == ST_SWAP2) ? dst_q : src_q;
        rf_write_addr = (state_q == ST_SWAP2) ? src_q : dst_q;
        drv_data      = (state_q == ST_SWAP3) ? data_q : wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_READ: begin
                        rf_read_en = 1'b1;
                        state_d    = ST_RESP;
                    end
                    OP_WRITE: begin
                        drv_en      = 1'b1;
                        rf_write_en = 1'b1;
                        state_d     = ST_RESP;
                    end
                    OP_MOVE: begin
                        rf_read_en  = 1'b1;
                        rf_write_en = 1'b1;
                        state_d     = ST_RESP;
                    end
                    default: begin
                        rf_read_en = 1'b1;
                        state_d    = ST_SWAP2;
                    end
                endcase
            end
            // dst flows over the bus into src while the old src sits in data_q.
            ST_SWAP2: begin
                rf_read_en  = 1'b1;
                rf_write_en = 1'b1;
                state_d     = ST_SWAP3;
            end
            ST_SWAP3: begin
                drv_en      = 1'b1;
                rf_write_en = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (op_q == OP_READ || op_q == OP_SWAP) begin
                    rsp_data = data_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            state_d       = ST_IDLE;
            req_ready     = 2'b00;
            rsp_valid     = 2'b00;
            rsp_data      = '0;
            rf_read_en    = 1'b0;
            rf_write_en   = 1'b0;
            drv_en        = 1'b0;
            rf_read_addr  = '0;
            rf_write_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            src_q   <= '0;
            dst_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_e'(sel ? req_op[3:2] : req_op[1:0]);
                src_q   <= sel ? req_src[2*ADDR_W-1:ADDR_W] : req_src[ADDR_W-1:0];
                dst_q   <= sel ? req_dst[2*ADDR_W-1:ADDR_W] : req_dst[ADDR_W-1:0];
                wdata_q <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                owner_q <= sel;
            end
            if (state_q == ST_EXEC && (op_q == OP_READ || op_q == OP_SWAP)) begin
                data_q <= bus;
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_scheduler.sv
// tb/tb_reg_bus_scheduler.sv - directed self-checking bench with a behavioural 16x8 register file on the bus
module tb_reg_bus_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_src;
    logic [7:0]  req_dst;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  rf_read_addr;
    logic        rf_read_en;
    logic [3:0]  rf_write_addr;
    logic        rf_write_en;
    wire  [7:0]  bus;

    logic [7:0] regs [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    int n_tests = 0;
    int n_fail  = 0;
    int viol_cnt = 0;
    int busx_cnt = 0;
    int drv_cnt  = 0;

    reg_bus_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rf_read_addr  (rf_read_addr),
        .rf_read_en    (rf_read_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_en   (rf_write_en),
        .bus           (bus)
    );

    assign bus = rf_read_en ? regs[rf_read_addr] : 8'bz;

    always @(posedge clk) begin
        if (rf_write_en) regs[rf_write_addr] <= bus;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (rf_read_en && dut.drv_en) viol_cnt++;
        if ((rf_read_en || rf_write_en || dut.drv_en) && $isunknown(bus)) busx_cnt++;
        if (dut.drv_en) drv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command from requester r; en1 returns {read_en, write_en, drv_en} seen in cycle N+1.
    task automatic run_cmd(input string tag, input int r, input logic [1:0] op,
                           input logic [3:0] src, input logic [3:0] dst, input logic [7:0] wd,
                           input int lat, input logic [7:0] exp_data, output logic [2:0] en1);
        int k;
        int c;
        @(negedge clk);
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        req_op[2*r +: 2]    = op;
        req_src[4*r +: 4]   = src;
        req_dst[4*r +: 4]   = dst;
        req_wdata[8*r +: 8] = wd;
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk({tag, "_ready"}, req_ready, 32'(2'b01 << r));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        c = 1;
        en1 = {rf_read_en, rf_write_en, dut.drv_en};
        while (rsp_valid == 2'b00 && c < 12) begin
            @(negedge clk); #1; c++;
        end
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_owner"}, rsp_valid, 32'(2'b01 << r));
        chk({tag, "_data"}, rsp_data, exp_data);
        @(negedge clk); #1;
        chk({tag, "_pulse"}, rsp_valid, 2'b00);
    endtask

    logic [2:0] en;
    logic [1:0] grants [4];
    logic [1:0] rsp_seen;
    int g;
    int d0;

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        req_op = 4'h0;
        req_src = 8'h00;
        req_dst = 8'h00;
        req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_data}, 10'h000);
        chk("rst_en", {rf_read_en, rf_write_en, dut.drv_en}, 3'b000);
        chk("rst_addr", {rf_read_addr, rf_write_addr}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;

        d0 = drv_cnt;
        run_cmd("read5", 0, 2'b00, 4'd5, 4'd0, 8'h00, 2, 8'h05, en);
        chk("read5_exec", en, 3'b100);
        chk("read5_nodrv", drv_cnt - d0, 0);

        run_cmd("wr3", 1, 2'b01, 4'd0, 4'd3, 8'hA5, 2, 8'h00, en);
        chk("wr3_exec", en, 3'b011);
        run_cmd("rd3", 1, 2'b00, 4'd3, 4'd0, 8'h00, 2, 8'hA5, en);

        run_cmd("mv72", 0, 2'b10, 4'd7, 4'd2, 8'h00, 2, 8'h00, en);
        chk("mv72_exec", en, 3'b110);
        run_cmd("rd2", 0, 2'b00, 4'd2, 4'd0, 8'h00, 2, 8'h07, en);
        run_cmd("rd7", 0, 2'b00, 4'd7, 4'd0, 8'h00, 2, 8'h07, en);

        // SWAP 1<->4 aborted by reset in the SWAP2 cycle.
        @(negedge clk);
        req_valid = 2'b01;
        req_op[1:0] = 2'b11;
        req_src[3:0] = 4'd1;
        req_dst[3:0] = 4'd4;
        #1;
        chk("abort_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_wen", rf_write_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 2'b00;
        repeat (6) begin
            #1; rsp_seen |= rsp_valid; @(negedge clk);
        end
        chk("abort_norsp", rsp_seen, 2'b00);
        chk("abort_reg1", regs[1], 8'h01);
        chk("abort_reg4", regs[4], 8'h04);

        // Both requesters held: alternation starting with req0.
        req_valid = 2'b11;
        req_op = 4'h0;
        req_src = {4'd9, 4'd5};
        g = 0;
        for (int cyc = 0; cyc < 60 && g < 4; cyc++) begin
            #1;
            if (req_ready != 2'b00) begin
                grants[g] = req_ready;
                g++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_count", g, 4);
        chk("rr_g0", grants[0], 2'b01);
        chk("rr_g1", grants[1], 2'b10);
        chk("rr_g2", grants[2], 2'b01);
        chk("rr_g3", grants[3], 2'b10);
        repeat (4) @(negedge clk);

        run_cmd("pre_rd1", 0, 2'b00, 4'd1, 4'd0, 8'h00, 2, 8'h01, en);
        run_cmd("pre_rd4", 0, 2'b00, 4'd4, 4'd0, 8'h00, 2, 8'h04, en);
        run_cmd("swap14", 0, 2'b11, 4'd1, 4'd4, 8'h00, 4, 8'h01, en);
        chk("swap14_exec", en, 3'b100);
        run_cmd("post_rd1", 0, 2'b00, 4'd1, 4'd0, 8'h00, 2, 8'h04, en);
        run_cmd("post_rd4", 0, 2'b00, 4'd4, 4'd0, 8'h00, 2, 8'h01, en);

        chk("no_contention", viol_cnt, 0);
        chk("bus_known", busx_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_scheduler.md
Name: reg_bus_scheduler

Overview:
- Sequences the 16x8 register file and the shared 8-bit tri-state bus on behalf of two requesters, for example the execute unit (req 0) and the debug/load port (req 1).
- Arbitrates requests round-robin and decodes each accepted command (READ, WRITE, MOVE, SWAP) into per-cycle register-file read/write enables and addresses.
- Owns the only controller-side bus driver and guarantees no bus contention.

Parameters:
- DATA_W, 8, bus and register width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester command valid (bit i = requester i).
- req_ready  out  2  one-hot grant; handshake completes when valid & ready.
- req_op  in  4  2 bits per requester, [2i+1:2i]; 00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
- req_src  in  2*ADDR_W  per-requester source register.
- req_dst  in  2*ADDR_W  per-requester destination register.
- req_wdata  in  2*DATA_W  per-requester write data (WRITE only).
- rsp_valid  out  2  one-hot completion pulse to the owning requester.
- rsp_data  out  DATA_W  response data, shared by both requesters.
- rf_read_addr  out  ADDR_W  register file read address.
- rf_read_en  out  1  register file drives the bus.
- rf_write_addr  out  ADDR_W  register file write address.
- rf_write_en  out  1  register file captures the bus at the next rising edge.
- bus  inout  DATA_W  shared bus; driven by this block only when drv_en=1, else high-Z.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rf_read_en=0, rf_write_en=0, both addresses 0, drv_en=0 (bus high-Z), state=IDLE, last_grant=1 (so req 0 wins first).
- States: IDLE, EXEC, SWAP2, SWAP3, RESP.
- IDLE:
  - If any req_valid is set, grant per round-robin: prefer the requester other than last_grant; a lone requester always wins.
  - req_ready (combinational) is high for the granted requester this cycle only.
  - Latch op/src/dst/wdata and the owner, update last_grant, go to EXEC.
- Requester rules: valid must be held and payload kept stable until ready. req_ready is never asserted outside IDLE or while rst=1.
- EXEC:
  - READ: read_en=1, read_addr=src; capture bus into data_q at the edge; go to RESP.
  - WRITE: drv_en=1 driving wdata, write_en=1, write_addr=dst; go to RESP.
  - MOVE: read_en=1 (src), write_en=1 (dst) in the same cycle; go to RESP. src==dst is legal and leaves the register unchanged.
  - SWAP: read_en=1 (src); capture the bus into data_q; go to SWAP2.
- SWAP2: read_en=1 (dst), write_en=1 (write_addr=src); go to SWAP3.
- SWAP3: drv_en=1 driving data_q, write_en=1 (write_addr=dst); go to RESP. src==dst runs the full sequence with a net unchanged result.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle.
  - rsp_data = data_q for READ and SWAP (SWAP returns the original src value); 0 for WRITE and MOVE.
  - Go to IDLE.
- Latency from handshake cycle N:
  - READ, WRITE, MOVE: response at N+2.
  - SWAP: response at N+4.
  - Next grant no earlier than response+1.
- Output timing: enables, addresses and drv_en are a combinational decode of state/latched command, all gated by !rst. No register write occurs in any cycle with rst=1.
- Invariants:
  - rf_read_en & drv_en never both 1.
  - rf_write_en never 1 in IDLE or RESP.
  - When inactive, addresses hold the latched command values (no glitch requirements).
- Reset mid-operation: abort to IDLE with last_grant=1; no rsp_valid for the aborted command. Writes already committed before the reset cycle remain.

Decomposition:
- Package reg_bus_pkg:
  - op encodings OP_READ/OP_WRITE/OP_MOVE/OP_SWAP;
  - state encodings;
  - DATA_W/ADDR_W defaults.
- Sub-module rr_arbiter_2 provides the 2-way round-robin grant with a last_grant register; its inputs are valid and an update strobe.
- The FSM and datapath latches live in the top module.

Test Plan (register file power-up contents regs[i]=i):
- req0 READ src=5 -> req_ready=01 at N; rf_read_en at N+1; rsp_valid=01, rsp_data=0x05 at N+2; drv_en never 1.
- req1 WRITE dst=3 wdata=0xA5, then req1 READ src=3 -> rsp_data=0xA5; rsp_valid=10 both times.
- req0 MOVE src=7 dst=2, then READ 2 and READ 7 -> both 0x07; MOVE exec cycle shows read_en=write_en=1, drv_en=0.
- req0 SWAP src=1 dst=4 -> rsp_data=0x01 at N+4; afterwards READ 1 -> 0x04, READ 4 -> 0x01.
- Both req_valid held high issuing READs -> grants 01,10,01,10; first grant goes to req0 after reset.
- rst=1 during SWAP2 of SWAP src=1 dst=4 -> no write_en that cycle; no rsp_valid; reg1=0x01 and reg4=0x04 unchanged. Next simultaneous request is granted to req0.
- Bench-wide assertion on every cycle of every test: never (rf_read_en & drv_en); no X on bus while any enable is high.
